// File: rtl/packet_source_gen.sv
// Synthetic traffic source for a ring-NoC injection port: periodic injection events
// queue up in a saturating pending counter and drain through a one-entry output register.
module packet_source_gen #(
  parameter int NUM_NODES            = 8,
  parameter int ROUTER_ID            = 0,
  parameter int ADDR_W               = 16,
  parameter int TS_W                 = 16,
  parameter int PACKET_SIZE          = 1 + TS_W + 2 * ADDR_W,
  parameter int TRAFFIC_PATTERN      = 0,
  parameter int HOTSPOT_ID           = 0,
  parameter int INJECT_PERIOD        = 2,
  parameter int NUM_PACKETS_PER_NODE = 20,
  parameter int PEND_DEPTH           = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [TS_W-1:0]        clk_counter,
  input  logic                   packet_ready,
  output logic                   packet_valid,
  output logic [PACKET_SIZE-1:0] packet,
  output logic [63:0]            total_packet_sent,
  output logic [31:0]            total_packet_dropped,
  output logic                   done
);

  if (PACKET_SIZE != 1 + TS_W + 2 * ADDR_W) begin : g_bad_packet_size
    $error("PACKET_SIZE must equal 1 + TS_W + 2*ADDR_W");
  end

  localparam int PH_W   = (INJECT_PERIOD > 1) ? $clog2(INJECT_PERIOD) : 1;
  localparam int PEND_W = $clog2(PEND_DEPTH + 1);
  localparam int RW     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(INJECT_PERIOD - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(PEND_DEPTH);
  localparam logic [31:0]       BUDGET    = 32'(NUM_PACKETS_PER_NODE);
  localparam logic              UNLIMITED = (NUM_PACKETS_PER_NODE == 0);
  localparam logic [15:0]       SEED      = 16'(ROUTER_ID + 1);

  localparam int NEIGH_I = (ROUTER_ID + 1 >= NUM_NODES) ? ROUTER_ID + 1 - NUM_NODES : ROUTER_ID + 1;
  localparam int TORN_I  = (ROUTER_ID + NUM_NODES / 2 >= NUM_NODES) ?
                           ROUTER_ID + NUM_NODES / 2 - NUM_NODES : ROUTER_ID + NUM_NODES / 2;
  localparam int HOT_I   = (HOTSPOT_ID == ROUTER_ID) ? NEIGH_I : HOTSPOT_ID;

  localparam logic [ADDR_W-1:0] SRC       = ADDR_W'(ROUTER_ID);
  localparam logic [ADDR_W-1:0] NODES     = ADDR_W'(NUM_NODES);
  localparam logic [ADDR_W-1:0] BITC_DST  = ADDR_W'(NUM_NODES - 1 - ROUTER_ID);
  localparam logic [ADDR_W-1:0] NEIGH_DST = ADDR_W'(NEIGH_I);
  localparam logic [ADDR_W-1:0] TORN_DST  = ADDR_W'(TORN_I);
  localparam logic [ADDR_W-1:0] HOT_DST   = ADDR_W'(HOT_I);

  logic [PH_W-1:0]   phase;
  logic [PEND_W-1:0] pend;
  logic [31:0]       gen_cnt;
  logic [15:0]       lfsr;
  logic              lfsr_fb;

  logic budget_left;
  logic inj;
  logic load;
  logic acc;
  logic drop;
  logic handshake;

  logic [ADDR_W-1:0] r_ext;
  logic [ADDR_W-1:0] r_wrap;
  logic [ADDR_W-1:0] rand_dst;
  logic [ADDR_W-1:0] dst;

  // Valid/ready: a packet transfers in any cycle where packet_valid && packet_ready;
  // once valid is raised, packet and packet_valid hold until that transfer happens.
  assign budget_left = UNLIMITED || (gen_cnt < BUDGET);
  assign inj         = en && (phase == PH_LAST) && budget_left;
  assign load        = (pend != '0) && (!packet_valid || packet_ready);
  assign acc         = inj && ((pend < PEND_MAX) || load);
  assign drop        = inj && !acc;
  assign handshake   = packet_valid && packet_ready;
  assign done        = !UNLIMITED && !budget_left && (pend == '0) && !packet_valid;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Uniform-random target: fold the low bits once into range; a hit on our own
  // address becomes address+1, which is exactly the neighbour destination.
  always_comb begin
    r_ext           = '0;
    r_ext[RW-1:0]   = lfsr[RW-1:0];
    r_wrap          = (r_ext >= NODES) ? r_ext - NODES : r_ext;
    rand_dst        = (r_wrap == SRC) ? NEIGH_DST : r_wrap;
  end

  always_comb begin
    dst = '0;
    case (TRAFFIC_PATTERN)
      0:       dst = BITC_DST;
      1:       dst = NEIGH_DST;
      2:       dst = TORN_DST;
      3:       dst = rand_dst;
      4:       dst = HOT_DST;
      default: dst = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      gen_cnt <= '0;
      pend    <= '0;
    end else begin
      if (en) begin
        phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      end
      if (inj) begin
        gen_cnt <= gen_cnt + 32'd1;
      end
      if (acc && !load) begin
        pend <= pend + PEND_W'(1);
      end else if (load && !acc) begin
        pend <= pend - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      packet_valid <= 1'b0;
      packet       <= '0;
      lfsr         <= SEED;
    end else if (load) begin
      packet_valid <= 1'b1;
      packet       <= {1'b1, clk_counter, SRC, dst};
      lfsr         <= {lfsr[14:0], lfsr_fb};
    end else if (handshake) begin
      packet_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_packet_sent    <= '0;
      total_packet_dropped <= '0;
    end else begin
      if (handshake) begin
        total_packet_sent <= total_packet_sent + 64'd1;
      end
      if (drop) begin
        total_packet_dropped <= total_packet_dropped + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_packet_source_gen.sv
// Bench for packet_source_gen: five differently parameterised sources run side by side
// against a cycle model built from the source's rules, plus hand-computed spot values.
module tb_packet_source_gen;

  localparam int N = 5;

  typedef struct {
    int nn;
    int rid;
    int pat;
    int hot;
    int ip;
    int budget;
    int depth;
  } cfg_t;

  cfg_t cfg [N];

  logic        clk;
  logic [15:0] clk_counter;
  logic        rst_n_i  [N];
  logic        en_i     [N];
  logic        ready_i  [N];
  logic        pv       [N];
  logic [48:0] pkt      [N];
  logic [63:0] sent     [N];
  logic [31:0] dropped  [N];
  logic        done_o   [N];

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] c0;

  // model state
  int          m_cnt   [N];
  int          m_gen   [N];
  int          m_pend  [N];
  bit          m_valid [N];
  logic [48:0] m_pkt   [N];
  longint      m_sent  [N];
  int          m_drop  [N];
  int          m_lfsr  [N];
  logic [48:0] exp_q[$];

  initial begin
    cfg[0] = '{nn: 8, rid: 2, pat: 0, hot: 0, ip: 2, budget: 3,    depth: 4};
    cfg[1] = '{nn: 8, rid: 7, pat: 1, hot: 0, ip: 1, budget: 0,    depth: 4};
    cfg[2] = '{nn: 8, rid: 6, pat: 2, hot: 0, ip: 1, budget: 0,    depth: 4};
    cfg[3] = '{nn: 8, rid: 3, pat: 4, hot: 3, ip: 1, budget: 0,    depth: 4};
    cfg[4] = '{nn: 6, rid: 2, pat: 3, hot: 0, ip: 1, budget: 1000, depth: 4};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  packet_source_gen #(.NUM_NODES(8), .ROUTER_ID(2), .TRAFFIC_PATTERN(0), .HOTSPOT_ID(0),
    .INJECT_PERIOD(2), .NUM_PACKETS_PER_NODE(3), .PEND_DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n_i[0]), .en(en_i[0]), .clk_counter(clk_counter),
    .packet_ready(ready_i[0]), .packet_valid(pv[0]), .packet(pkt[0]),
    .total_packet_sent(sent[0]), .total_packet_dropped(dropped[0]), .done(done_o[0]));

  packet_source_gen #(.NUM_NODES(8), .ROUTER_ID(7), .TRAFFIC_PATTERN(1), .HOTSPOT_ID(0),
    .INJECT_PERIOD(1), .NUM_PACKETS_PER_NODE(0), .PEND_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n_i[1]), .en(en_i[1]), .clk_counter(clk_counter),
    .packet_ready(ready_i[1]), .packet_valid(pv[1]), .packet(pkt[1]),
    .total_packet_sent(sent[1]), .total_packet_dropped(dropped[1]), .done(done_o[1]));

  packet_source_gen #(.NUM_NODES(8), .ROUTER_ID(6), .TRAFFIC_PATTERN(2), .HOTSPOT_ID(0),
    .INJECT_PERIOD(1), .NUM_PACKETS_PER_NODE(0), .PEND_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n_i[2]), .en(en_i[2]), .clk_counter(clk_counter),
    .packet_ready(ready_i[2]), .packet_valid(pv[2]), .packet(pkt[2]),
    .total_packet_sent(sent[2]), .total_packet_dropped(dropped[2]), .done(done_o[2]));

  packet_source_gen #(.NUM_NODES(8), .ROUTER_ID(3), .TRAFFIC_PATTERN(4), .HOTSPOT_ID(3),
    .INJECT_PERIOD(1), .NUM_PACKETS_PER_NODE(0), .PEND_DEPTH(4)) u3 (
    .clk(clk), .rst_n(rst_n_i[3]), .en(en_i[3]), .clk_counter(clk_counter),
    .packet_ready(ready_i[3]), .packet_valid(pv[3]), .packet(pkt[3]),
    .total_packet_sent(sent[3]), .total_packet_dropped(dropped[3]), .done(done_o[3]));

  packet_source_gen #(.NUM_NODES(6), .ROUTER_ID(2), .TRAFFIC_PATTERN(3), .HOTSPOT_ID(0),
    .INJECT_PERIOD(1), .NUM_PACKETS_PER_NODE(1000), .PEND_DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n_i[4]), .en(en_i[4]), .clk_counter(clk_counter),
    .packet_ready(ready_i[4]), .packet_valid(pv[4]), .packet(pkt[4]),
    .total_packet_sent(sent[4]), .total_packet_dropped(dropped[4]), .done(done_o[4]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int dst_of(input int i);
    int nn, rid, r;
    nn  = cfg[i].nn;
    rid = cfg[i].rid;
    case (cfg[i].pat)
      0: return nn - 1 - rid;
      1: return (rid + 1) % nn;
      2: return (rid + nn / 2) % nn;
      3: begin
        r = m_lfsr[i] % (1 << $clog2(nn));
        if (r >= nn) r = r - nn;
        return (r == rid) ? (rid + 1) % nn : r;
      end
      4: return (cfg[i].hot == rid) ? (rid + 1) % nn : cfg[i].hot;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset(input int i);
    m_cnt[i]   = 0;
    m_gen[i]   = 0;
    m_pend[i]  = 0;
    m_valid[i] = 0;
    m_pkt[i]   = '0;
    m_sent[i]  = 0;
    m_drop[i]  = 0;
    m_lfsr[i]  = cfg[i].rid + 1;
    if (i == 4) exp_q.delete();
  endtask

  task automatic model_step(input int i);
    bit bl, inj, load, hs, acc;
    int fb, l;
    bl   = (cfg[i].budget == 0) || (m_gen[i] < cfg[i].budget);
    inj  = en_i[i] && ((m_cnt[i] % cfg[i].ip) == cfg[i].ip - 1) && bl;
    load = (m_pend[i] > 0) && (!m_valid[i] || ready_i[i]);
    hs   = m_valid[i] && ready_i[i];
    acc  = inj && (m_pend[i] < cfg[i].depth || load);
    if (en_i[i]) m_cnt[i] = m_cnt[i] + 1;
    if (inj) m_gen[i] = m_gen[i] + 1;
    if (inj && !acc) m_drop[i] = m_drop[i] + 1;
    if (hs) m_sent[i] = m_sent[i] + 1;
    m_pend[i] = m_pend[i] + (acc ? 1 : 0) - (load ? 1 : 0);
    if (load) begin
      m_pkt[i]   = {1'b1, clk_counter, 16'(cfg[i].rid), 16'(dst_of(i))};
      m_valid[i] = 1;
      if (i == 4) exp_q.push_back(m_pkt[i]);
      l  = m_lfsr[i];
      fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
      m_lfsr[i] = ((l << 1) | fb) & 16'hFFFF;
    end else if (hs) begin
      m_valid[i] = 0;
    end
  endtask

  task automatic compare(input int i);
    bit exp_done;
    logic [48:0] head;
    exp_done = (cfg[i].budget != 0) && (m_gen[i] >= cfg[i].budget) &&
               (m_pend[i] == 0) && !m_valid[i];
    chk($sformatf("u%0d.valid", i),   64'(pv[i]),      64'(m_valid[i]));
    chk($sformatf("u%0d.packet", i),  64'(pkt[i]),     64'(m_pkt[i]));
    chk($sformatf("u%0d.sent", i),    sent[i],         64'(m_sent[i]));
    chk($sformatf("u%0d.dropped", i), 64'(dropped[i]), 64'(m_drop[i]));
    chk($sformatf("u%0d.done", i),    64'(done_o[i]),  64'(exp_done));
    if (i == 4 && pv[4] === 1'b1 && ready_i[4] === 1'b1) begin
      chk("u4.dst_legal", 64'((pkt[4][15:0] < 16'd6) && (pkt[4][15:0] != 16'd2)), 64'd1);
      if (exp_q.size() == 0) begin
        chk("u4.unexpected_packet", 64'(pkt[4]), 64'd0);
      end else begin
        head = exp_q.pop_front();
        chk("u4.scoreboard", 64'(pkt[4]), 64'(head));
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rst_n_i[i]) model_reset(i);
        compare(i);
        if (rst_n_i[i]) model_step(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    clk_counter = clk_counter + 16'd1;
  endtask

  task automatic set_inputs(input int n);
    en_i[0]    = !(n >= 4 && n <= 6);
    ready_i[0] = 1'b1;
    ready_i[1] = (n >= 10);
    ready_i[2] = 1'b1;
    ready_i[3] = (n < 6) || (n >= 10);
    rst_n_i[3] = !(n == 8 || n == 9);
    ready_i[4] = 1'b1;
  endtask

  task automatic spot_checks(input int c);
    case (c)
      0: begin
        chk("u0.done_at_reset", 64'(done_o[0]), 64'd0);
        chk("u0.valid_at_reset", 64'(pv[0]), 64'd0);
      end
      2: begin
        chk("u0.valid_c2", 64'(pv[0]), 64'd0);
        chk("u3.hotspot_dst", 64'(pkt[3][15:0]), 64'd4);
        chk("u3.hotspot_src", 64'(pkt[3][31:16]), 64'd3);
        chk("u4.rand_dst_1", 64'(pkt[4][15:0]), 64'd3);
      end
      3: begin
        chk("u0.first_valid_c3", 64'(pv[0]), 64'd1);
        chk("u0.first_packet", 64'(pkt[0]), 64'({1'b1, c0 + 16'd2, 16'd2, 16'd5}));
        chk("u4.rand_dst_2", 64'(pkt[4][15:0]), 64'd0);
      end
      4: chk("u4.rand_dst_3", 64'(pkt[4][15:0]), 64'd4);
      7: chk("u3.sent_before_reset", sent[3], 64'd4);
      8: begin
        chk("u3.reset_valid", 64'(pv[3]), 64'd0);
        chk("u3.reset_packet", 64'(pkt[3]), 64'd0);
        chk("u3.reset_sent", sent[3], 64'd0);
        chk("u3.reset_dropped", 64'(dropped[3]), 64'd0);
      end
      10: begin
        chk("u0.done_c10", 64'(done_o[0]), 64'd0);
        chk("u0.third_dst", 64'(pkt[0][15:0]), 64'd5);
        chk("u1.dropped_after_stall", 64'(dropped[1]), 64'd5);
      end
      11: begin
        chk("u0.done_c11", 64'(done_o[0]), 64'd1);
        chk("u0.sent_total", sent[0], 64'd3);
        chk("u0.dropped_total", 64'(dropped[0]), 64'd0);
        chk("u3.valid_c11_after_reset", 64'(pv[3]), 64'd0);
      end
      12: begin
        chk("u3.valid_c12_after_reset", 64'(pv[3]), 64'd1);
        chk("u3.packet_after_reset", 64'(pkt[3]), 64'({1'b1, c0 + 16'd11, 16'd3, 16'd4}));
      end
      20: begin
        chk("u1.dropped_c20", 64'(dropped[1]), 64'd5);
        chk("u2.sent_c20", sent[2], 64'd18);
        chk("u2.dropped_c20", 64'(dropped[2]), 64'd0);
        chk("u2.packet_c20", 64'(pkt[2]), 64'({1'b1, c0 + 16'd19, 16'd6, 16'd2}));
      end
      1005: begin
        chk("u4.done", 64'(done_o[4]), 64'd1);
        chk("u4.sent_total", sent[4], 64'd1000);
        chk("u4.queue_drained", 64'(exp_q.size()), 64'd0);
      end
      default: ;
    endcase
    if (c >= 2 && c <= 9) begin
      chk("u1.held_valid", 64'(pv[1]), 64'd1);
      chk("u1.held_packet", 64'(pkt[1]), 64'({1'b1, c0 + 16'd1, 16'd7, 16'd0}));
    end
  endtask

  initial begin
    clk_counter = '0;
    for (int i = 0; i < N; i++) begin
      rst_n_i[i] = 1'b0;
      en_i[i]    = 1'b1;
      ready_i[i] = 1'b0;
    end
    repeat (3) tick();
    for (int i = 0; i < N; i++) rst_n_i[i] = 1'b1;
    set_inputs(0);
    c0 = clk_counter;
    for (int c = 0; c < 1012; c++) begin
      @(negedge clk);
      spot_checks(c);
      tick();
      set_inputs(c + 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
